// File: rtl/red_pitaya_pwm_dither.sv
// red_pitaya_pwm_dither
//   Converts a signed 14-bit level into a glitch-free PWM bit stream.
//   The top CCW bits of the offset-binary level set the duty of each
//   (2^CCW-1)-cycle period; the next DITH bits are spread over a
//   2^DITH-period cycle by a first-order accumulator, so the fraction
//   appears as an occasional period one count longer.
//
// Ports
//   clk_i    : processing clock, rising edge
//   rst_i    : synchronous active-high reset
//   dat_i    : signed two's-complement level (14 bits)
//   en_i     : output enable; low forces pwm_o to 0 from the next cycle
//   pwm_o    : registered PWM bit
//   period_o : one-cycle strobe on the last cycle of each period
//   duty_o   : duty value in use for the current period
//
// Requires CCW + DITH <= 13 so at least one level LSB is discarded.
module red_pitaya_pwm_dither #(
    parameter int CCW  = 8,
    parameter int DITH = 4
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [13:0]    dat_i,
    input  logic           en_i,
    output logic           pwm_o,
    output logic           period_o,
    output logic [CCW-1:0] duty_o
);

    // Last count of a period: 2^CCW-2, so a period is 2^CCW-1 cycles and
    // duty = 2^CCW-1 keeps the output high for the whole period.
    localparam logic [CCW-1:0] CNT_LAST = {{(CCW-1){1'b1}}, 1'b0};

    logic [13:0]     dat_r;
    logic [CCW-1:0]  cnt;
    logic [CCW-1:0]  duty;
    logic [DITH-1:0] acc;

    logic [13:0]     u;
    logic [CCW-1:0]  coarse;
    logic [DITH-1:0] frac;
    logic [DITH:0]   s;
    logic [CCW:0]    sum_duty;
    logic [CCW-1:0]  duty_nxt;
    logic            unused_lsbs;

    // Offset binary: flipping the sign bit maps -8192..8191 onto 0..16383.
    assign u      = {~dat_r[13], dat_r[12:0]};
    assign coarse = u[13 -: CCW];
    assign frac   = u[13-CCW -: DITH];
    // Bits below the dither fraction are truncated, not rounded.
    assign unused_lsbs = ^u[13-CCW-DITH:0];

    assign s        = {1'b0, acc} + {1'b0, frac};
    assign sum_duty = {1'b0, coarse} + {{CCW{1'b0}}, s[DITH]};
    // coarse = max with a carry would overflow; clamp to full-on.
    assign duty_nxt = sum_duty[CCW] ? {CCW{1'b1}} : sum_duty[CCW-1:0];

    assign period_o = (cnt == CNT_LAST);
    assign duty_o   = duty;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dat_r <= '0;
            cnt   <= '0;
            acc   <= '0;
            duty  <= '0;
            pwm_o <= 1'b0;
        end else begin
            dat_r <= dat_i;
            cnt   <= period_o ? '0 : cnt + 1'b1;
            // Duty and dither state change only at the period boundary, so
            // the output edges inside a period never move.
            if (period_o) begin
                acc  <= s[DITH-1:0];
                duty <= duty_nxt;
            end
            // Comparison uses the duty in force before this edge, so the
            // cnt==0 slot of a new period already sees the freshly loaded duty.
            pwm_o <= en_i & (cnt < duty);
        end
    end

endmodule

// File: tb/tb_red_pitaya_pwm_dither.sv
module tb_red_pitaya_pwm_dither;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic [13:0] dat = 14'h2000;
    logic        pwm;
    logic        per;
    logic [7:0]  duty;

    always #5 clk = ~clk;

    red_pitaya_pwm_dither #(.CCW(8), .DITH(4)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .dat_i    (dat),
        .en_i     (en),
        .pwm_o    (pwm),
        .period_o (per),
        .duty_o   (duty)
    );

    typedef struct {
        int duty;
        int hc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;

    // Reference model state: dither remainder and duty for the running period.
    int acc_m  = 0;
    int duty_m = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Boundary update from the level held at the end of a period.
    // Level -> offset 0..16383, coarse = /64, fraction = next 4 bits.
    task automatic model_boundary(input logic [13:0] d);
        int sv, u, coarse, frac;
        sv     = (d >= 14'd8192) ? int'(d) - 16384 : int'(d);
        u      = sv + 8192;
        coarse = u / 64;
        frac   = (u / 4) % 16;
        acc_m  = acc_m + frac;
        duty_m = coarse;
        if (acc_m >= 16) begin
            acc_m  = acc_m - 16;
            duty_m = coarse + 1;
        end
        if (duty_m > 255) duty_m = 255;
    endtask

    // Monitor: counts high PWM slots of each period and scores it when the
    // period closes (the sample after period_o shows the cnt=254 slot).
    int hc       = 0;
    bit prev_per = 1'b0;
    int duty_seen = 0;

    always @(negedge clk) begin
        if (rst) begin
            hc       = 0;
            prev_per = 1'b0;
        end else begin
            hc = hc + int'(pwm);
            if (prev_per) begin
                if (q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    e = q.pop_front();
                    check("duty_o", duty_seen, e.duty);
                    check("high_cycles", hc, e.hc);
                end
                hc = 0;
            end
            if (per) duty_seen = int'(duty);
            prev_per = per;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        q.delete();
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("rst_pwm_o", int'(pwm), 0);
        check("rst_period_o", int'(per), 0);
        check("rst_duty_o", int'(duty), 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        acc_m  = 0;
        duty_m = 0;
    endtask

    // Drives one period starting in the cycle where cnt == start (0 right
    // after a boundary or right after reset release). Optionally changes
    // dat at cnt==chg, drops en at cnt==drop, or resets at cnt==rst_at.
    task automatic run_period(input int start, input logic [13:0] nd, input int chg,
                              input bit en_p, input int drop, input int rst_at);
        exp_t x;
        int   h;
        bit   smp;
        en = en_p;
        h  = duty_m;
        if (drop >= 0 && drop < h) h = drop;
        if (!en_p) h = 0;
        x.duty = duty_m;
        x.hc   = h;
        q.push_back(x);
        for (int c = start; c < 255; c++) begin
            if (c == chg) dat = nd;
            if (c == drop) en = 1'b0;
            if (c == rst_at) begin
                do_reset();
                return;
            end
            smp = (c == 253) || (c == 254) || (drop >= 0 && c == drop + 1);
            if (smp) begin
                @(negedge clk);
                if (c >= 253) check("period_o_timing", int'(per), int'(c == 254));
                if (drop >= 0 && c == drop + 1) check("pwm_off_after_en_drop", int'(pwm), 0);
            end
            @(posedge clk);
            #1;
        end
        model_boundary(dat);
    endtask

    initial begin
        logic [13:0] rd;
        int          rc;
        bit          re;

        en  = 1'b1;
        dat = 14'h2000;
        do_reset();

        // Most negative level: duty 0, never high.
        run_period(0, 14'h2000, -1, 1'b1, -1, -1);
        run_period(0, 14'h2000, -1, 1'b1, -1, -1);

        // Most positive level: saturates to continuous high.
        run_period(0, 14'h1FFF, 10, 1'b1, -1, -1);
        run_period(0, 14'h1FFF, -1, 1'b1, -1, -1);
        run_period(0, 14'h1FFF, -1, 1'b1, -1, -1);

        // Mid-scale: 128 of 255 every period.
        run_period(0, 14'h0000, 20, 1'b1, -1, -1);
        run_period(0, 14'h0000, -1, 1'b1, -1, -1);

        // Fraction 4/16: dither over 16 periods.
        run_period(0, 14'h0010, 30, 1'b1, -1, -1);
        for (int i = 0; i < 16; i++) run_period(0, 14'h0010, -1, 1'b1, -1, -1);

        // Mid-period level change takes effect at the next boundary only.
        run_period(0, 14'h0000, 40, 1'b1, -1, -1);
        run_period(0, 14'h1000, 100, 1'b1, -1, -1);
        run_period(0, 14'h1000, -1, 1'b1, -1, -1);

        // Enable dropped at cnt 50 with duty 128.
        run_period(0, 14'h0000, 60, 1'b1, -1, -1);
        run_period(0, 14'h0000, -1, 1'b1, 50, -1);
        run_period(0, 14'h0000, -1, 1'b1, -1, -1);

        // Reset mid-period at cnt 200, then dither restarts from zero.
        run_period(0, 14'h0013, 70, 1'b1, -1, 200);
        run_period(0, 14'h0013, -1, 1'b1, -1, -1);
        run_period(0, 14'h0013, -1, 1'b1, -1, -1);
        run_period(0, 14'h0013, -1, 1'b1, -1, -1);

        // Randomized levels, change points and enables.
        for (int i = 0; i < 24; i++) begin
            rd = 14'($urandom_range(0, 16383));
            if (i % 8 == 3) rd = 14'h1FFF;
            if (i % 8 == 6) rd = 14'h2000;
            rc = int'($urandom_range(5, 250));
            re = ($urandom_range(0, 3) != 0);
            run_period(0, rd, rc, re, -1, -1);
        end

        @(negedge clk);
        @(negedge clk);
        check("sb_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
